// File: rtl/soc_system_onchip_ram_burst_dp.sv
// Dual-port on-chip RAM. Port s1 is a pipelined burst slave, port s2 is a
// fixed-latency single-word slave. Both ports share one clock and one
// true-dual-port memory array.
module soc_system_onchip_ram_burst_dp #(
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned ADDR_W    = 13,
  parameter int unsigned BURST_W   = 5,
  parameter int unsigned MAX_BURST = 16,
  parameter int unsigned OUT_REG   = 1,
  parameter string       INIT_FILE = "soc_system_onchip_ram_burst_dp.hex"
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clken,
  input  logic                  freeze,
  input  logic [ADDR_W-1:0]     s1_address,
  input  logic                  s1_chipselect,
  input  logic                  s1_read,
  input  logic                  s1_write,
  input  logic [BURST_W-1:0]    s1_burstcount,
  input  logic [DATA_W/8-1:0]   s1_byteenable,
  input  logic [DATA_W-1:0]     s1_writedata,
  output logic                  s1_waitrequest,
  output logic [DATA_W-1:0]     s1_readdata,
  output logic                  s1_readdatavalid,
  input  logic [ADDR_W-1:0]     s2_address,
  input  logic                  s2_chipselect,
  input  logic                  s2_write,
  input  logic [DATA_W/8-1:0]   s2_byteenable,
  input  logic [DATA_W-1:0]     s2_writedata,
  output logic [DATA_W-1:0]     s2_readdata
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {IDLE, RBURST, WBURST} state_t;

  // Contents are loaded from INIT_FILE by the device configuration flow.
  (* ram_init_file = INIT_FILE *) logic [DATA_W-1:0] mem [DEPTH];

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [BURST_W-1:0]  left_q, left_d;
  logic                wait_q, wait_d;
  logic [BURST_W-1:0]  burst_eff_c;
  logic                s1_rd_c, s1_wr_c;
  logic [ADDR_W-1:0]   s1_addr_c;
  logic                s2_rd_c, s2_wr_c;

  logic                rd1_vld, s2_v1;
  logic [DATA_W-1:0]   rd1_data, s2_d1;

  // Burst length normalisation: 0 means one beat, oversize bursts are clamped.
  always_comb begin
    burst_eff_c = s1_burstcount;
    if (s1_burstcount == '0)
      burst_eff_c = BURST_W'(1);
    else if (s1_burstcount > BURST_W'(MAX_BURST))
      burst_eff_c = BURST_W'(MAX_BURST);
  end

  // s1 next-state, burst address/count and RAM access strobes.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    left_d    = left_q;
    s1_rd_c   = 1'b0;
    s1_wr_c   = 1'b0;
    s1_addr_c = addr_q;
    case (state_q)
      IDLE: begin
        if (s1_chipselect && (s1_read || s1_write) && !wait_q) begin
          s1_addr_c = s1_address;
          addr_d    = s1_address + ADDR_W'(1);
          left_d    = burst_eff_c - BURST_W'(1);
          if (s1_read) begin
            s1_rd_c = 1'b1;
            if (burst_eff_c > BURST_W'(1)) state_d = RBURST;
          end else begin
            s1_wr_c = 1'b1;
            if (burst_eff_c > BURST_W'(1)) state_d = WBURST;
          end
        end
      end
      RBURST: begin
        s1_rd_c = 1'b1;
        addr_d  = addr_q + ADDR_W'(1);
        left_d  = left_q - BURST_W'(1);
        if (left_q == BURST_W'(1)) state_d = IDLE;
      end
      WBURST: begin
        if (s1_chipselect && s1_write) begin
          s1_wr_c = 1'b1;
          addr_d  = addr_q + ADDR_W'(1);
          left_d  = left_q - BURST_W'(1);
          if (left_q == BURST_W'(1)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    wait_d = (state_d == RBURST);
  end

  // s1 FSM and burst registers; clken low freezes everything.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      left_q  <= '0;
      wait_q  <= 1'b1;
    end else if (clken) begin
      state_q <= state_d;
      addr_q  <= addr_d;
      left_q  <= left_d;
      wait_q  <= wait_d;
    end
  end

  // s2 strobes; an s2 write to the word s1 is writing this cycle is dropped.
  always_comb begin
    s2_rd_c = s2_chipselect && !s2_write;
    s2_wr_c = s2_chipselect && s2_write && !(s1_wr_c && (s1_addr_c == s2_address));
  end

  // Byte-masked RAM writes on both ports, suppressed by freeze.
  always_ff @(posedge clk) begin
    if (clken && !freeze) begin
      for (int b = 0; b < BE_W; b++) begin
        if (s1_wr_c && s1_byteenable[b]) mem[s1_addr_c][b*8 +: 8] <= s1_writedata[b*8 +: 8];
        if (s2_wr_c && s2_byteenable[b]) mem[s2_address][b*8 +: 8] <= s2_writedata[b*8 +: 8];
      end
    end
  end

  // First read stage; sampling before the write lands returns old data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd1_vld  <= 1'b0;
      rd1_data <= '0;
      s2_v1    <= 1'b0;
      s2_d1    <= '0;
    end else if (clken) begin
      rd1_vld <= s1_rd_c;
      if (s1_rd_c) rd1_data <= mem[s1_addr_c];
      s2_v1 <= s2_rd_c;
      if (s2_rd_c) s2_d1 <= mem[s2_address];
    end
  end

  logic              out_vld;
  logic [DATA_W-1:0] out_data, out_s2;

  if (OUT_REG != 0) begin : g_out_reg
    logic              o_vld;
    logic [DATA_W-1:0] o_data, o_s2;

    // Optional second read stage; data registers only load on a valid beat.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        o_vld  <= 1'b0;
        o_data <= '0;
        o_s2   <= '0;
      end else if (clken) begin
        o_vld <= rd1_vld;
        if (rd1_vld) o_data <= rd1_data;
        if (s2_v1)   o_s2   <= s2_d1;
      end
    end

    assign out_vld  = o_vld;
    assign out_data = o_data;
    assign out_s2   = o_s2;
  end else begin : g_no_out_reg
    assign out_vld  = rd1_vld;
    assign out_data = rd1_data;
    assign out_s2   = s2_d1;
  end

  // A stalled clock must neither accept commands nor present a beat twice.
  assign s1_waitrequest   = wait_q | ~clken;
  assign s1_readdatavalid = out_vld & clken;
  assign s1_readdata      = out_data;
  assign s2_readdata      = out_s2;

endmodule

// File: tb/tb_soc_system_onchip_ram_burst_dp.sv
// Randomised scoreboard bench for the dual-port burst RAM.
module tb_soc_system_onchip_ram_burst_dp;

  localparam int DEPTH = 8192;

  logic        clk = 1'b0;
  logic        reset_n, clken, freeze;
  logic [12:0] s1_address;
  logic        s1_chipselect, s1_read, s1_write;
  logic [4:0]  s1_burstcount;
  logic [7:0]  s1_byteenable;
  logic [63:0] s1_writedata;
  logic        s1_waitrequest;
  logic [63:0] s1_readdata;
  logic        s1_readdatavalid;
  logic [12:0] s2_address;
  logic        s2_chipselect, s2_write;
  logic [7:0]  s2_byteenable;
  logic [63:0] s2_writedata;
  logic [63:0] s2_readdata;

  soc_system_onchip_ram_burst_dp dut (
    .clk(clk), .reset_n(reset_n), .clken(clken), .freeze(freeze),
    .s1_address(s1_address), .s1_chipselect(s1_chipselect), .s1_read(s1_read),
    .s1_write(s1_write), .s1_burstcount(s1_burstcount), .s1_byteenable(s1_byteenable),
    .s1_writedata(s1_writedata), .s1_waitrequest(s1_waitrequest),
    .s1_readdata(s1_readdata), .s1_readdatavalid(s1_readdatavalid),
    .s2_address(s2_address), .s2_chipselect(s2_chipselect), .s2_write(s2_write),
    .s2_byteenable(s2_byteenable), .s2_writedata(s2_writedata), .s2_readdata(s2_readdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    logic [63:0] exp;
  } exp_t;

  exp_t        s1q[$];
  exp_t        s2q[$];
  exp_t        mon_e;
  logic [63:0] mdl [int];
  logic [63:0] wdata [16];
  logic [7:0]  wbe [16];
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int clamp(input int n);
    return (n == 0) ? 1 : ((n > 16) ? 16 : n);
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] nw,
                                        input logic [7:0] be);
    logic [63:0] r;
    r = old;
    for (int b = 0; b < 8; b++) if (be[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  function automatic int wrap(input int a);
    return a % DEPTH;
  endfunction

  // Monitor: pops the scoreboards whenever the DUT presents read data.
  always @(negedge clk) begin
    if (s1_readdatavalid) begin
      if (s1q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL s1_unexpected_valid: got beat %h, expected no beat (cycle %0d)", s1_readdata, cyc);
      end else begin
        mon_e = s1q.pop_front();
        check("s1_readdata", s1_readdata, mon_e.exp);
        if (mon_e.due >= 0) check("s1_valid_cycle", 64'(cyc), 64'(mon_e.due));
      end
    end
    while (s2q.size() > 0 && s2q[0].due <= cyc) begin
      mon_e = s2q.pop_front();
      if (mon_e.due == cyc) check("s2_readdata", s2_readdata, mon_e.exp);
      else check("s2_missed_slot", 64'(cyc), 64'(mon_e.due));
    end
  end

  // Waits until the presented s1 command/beat is accepted; returns the accept edge count.
  task automatic wait_accept(output int acc);
    int   n;
    logic w;
    n = 0;
    forever begin
      @(negedge clk);
      w = s1_waitrequest;
      @(posedge clk);
      #1;
      if (!w) break;
      n++;
      if (n > 200) begin
        check("s1_accept_timeout", 64'(n), 64'(0));
        break;
      end
    end
    acc = cyc;
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (s1_waitrequest && k < 200);
    if (s1_waitrequest) check(name, 64'(s1_waitrequest), 64'(0));
    @(posedge clk);
    #1;
  endtask

  task automatic s2_write_t(input logic [12:0] a, input logic [63:0] d, input logic [7:0] be);
    s2_chipselect = 1'b1; s2_write = 1'b1; s2_address = a; s2_writedata = d; s2_byteenable = be;
    @(posedge clk);
    #1;
    s2_chipselect = 1'b0; s2_write = 1'b0;
    if (!freeze) mdl[int'(a)] = merge(mdl[int'(a)], d, be);
  endtask

  task automatic s2_read_t(input logic [12:0] a, input logic [63:0] exp);
    s2q.push_back('{cyc + 2, exp});
    s2_chipselect = 1'b1; s2_write = 1'b0; s2_address = a;
    @(posedge clk);
    #1;
    s2_chipselect = 1'b0;
  endtask

  task automatic s1_write_burst(input logic [12:0] a, input int n, input int gap_at);
    int eff, acc;
    eff = clamp(n);
    s1_chipselect = 1'b1; s1_read = 1'b0; s1_write = 1'b1;
    s1_address = a; s1_burstcount = 5'(n);
    for (int i = 0; i < eff; i++) begin
      if (i == gap_at && i > 0) begin
        s1_write = 1'b0;
        @(posedge clk);
        #1;
        s1_write = 1'b1;
      end
      s1_writedata = wdata[i]; s1_byteenable = wbe[i];
      wait_accept(acc);
      if (!freeze) mdl[wrap(int'(a) + i)] = merge(mdl[wrap(int'(a) + i)], wdata[i], wbe[i]);
    end
    s1_chipselect = 1'b0; s1_write = 1'b0;
  endtask

  task automatic s1_read_burst(input logic [12:0] a, input int n, input bit timed);
    int eff, acc;
    eff = clamp(n);
    s1_chipselect = 1'b1; s1_read = 1'b1; s1_write = 1'b0;
    s1_address = a; s1_burstcount = 5'(n);
    wait_accept(acc);
    s1_chipselect = 1'b0; s1_read = 1'b0;
    for (int i = 0; i < eff; i++)
      s1q.push_back('{timed ? acc + 1 + i : -1, mdl[wrap(int'(a) + i)]});
    if (eff > 1) begin
      @(negedge clk);
      check("s1_wait_in_rburst", 64'(s1_waitrequest), 64'(1));
    end
    wait_idle("s1_rburst_end_timeout");
  endtask

  initial begin
    int          acc, k;
    logic [63:0] old;
    reset_n = 1'b0; clken = 1'b1; freeze = 1'b0;
    s1_address = '0; s1_chipselect = 1'b0; s1_read = 1'b0; s1_write = 1'b0;
    s1_burstcount = '0; s1_byteenable = '0; s1_writedata = '0;
    s2_address = '0; s2_chipselect = 1'b0; s2_write = 1'b0;
    s2_byteenable = '0; s2_writedata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_waitrequest", 64'(s1_waitrequest), 64'(1));
    check("rst_valid", 64'(s1_readdatavalid), 64'(0));
    check("rst_s1_readdata", s1_readdata, 64'h0);
    check("rst_s2_readdata", s2_readdata, 64'h0);
    reset_n = 1'b1;
    @(negedge clk);
    check("rel_waitrequest_pre_edge", 64'(s1_waitrequest), 64'(1));
    @(posedge clk);
    #1;
    check("rel_waitrequest_post_edge", 64'(s1_waitrequest), 64'(0));
    check("rel_valid", 64'(s1_readdatavalid), 64'(0));

    // Give every address the bench touches a known value.
    for (int a = 16'h1FF0; a <= 16'h1FFF; a++) s2_write_t(13'(a), {$urandom, $urandom}, 8'hFF);
    for (int a = 0; a < 16'h40; a++)           s2_write_t(13'(a), {$urandom, $urandom}, 8'hFF);
    for (int a = 16'h100; a < 16'h180; a++)    s2_write_t(13'(a), {$urandom, $urandom}, 8'hFF);
    s2_read_t(13'h0, mdl[0]);

    // Wrapping write burst with a mid-burst gap, then read it back.
    for (int i = 0; i < 4; i++) begin wdata[i] = 64'hA0 + 64'(i); wbe[i] = 8'hFF; end
    s1_write_burst(13'h1FFE, 4, 2);
    s1_read_burst(13'h1FFE, 4, 1'b1);
    s2_read_t(13'h0001, 64'hA3);

    // Partial byte-enable write over all-ones.
    s2_write_t(13'h20, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    s2_write_t(13'h20, 64'h1111_2222_3333_4444, 8'h0F);
    s2_read_t(13'h20, 64'hFFFF_FFFF_3333_4444);
    repeat (4) @(posedge clk);
    #1;
    check("s2_readdata_hold", s2_readdata, 64'hFFFF_FFFF_3333_4444);

    // Same-cycle writes from both ports to one word: s1 wins.
    s1_chipselect = 1'b1; s1_write = 1'b1; s1_address = 13'h10; s1_burstcount = 5'd1;
    s1_byteenable = 8'hFF; s1_writedata = 64'h55;
    s2_chipselect = 1'b1; s2_write = 1'b1; s2_address = 13'h10;
    s2_byteenable = 8'hFF; s2_writedata = 64'h66;
    @(negedge clk);
    check("coll_ww_accept", 64'(s1_waitrequest), 64'(0));
    @(posedge clk);
    #1;
    s1_chipselect = 1'b0; s1_write = 1'b0; s2_chipselect = 1'b0; s2_write = 1'b0;
    mdl[16'h10] = 64'h55;
    s2_read_t(13'h10, 64'h55);

    // s2 read of the word s1 writes in the same cycle returns old data.
    old = mdl[16'h11];
    s2q.push_back('{cyc + 2, old});
    s1_chipselect = 1'b1; s1_write = 1'b1; s1_address = 13'h11; s1_burstcount = 5'd1;
    s1_byteenable = 8'hFF; s1_writedata = 64'h77;
    s2_chipselect = 1'b1; s2_write = 1'b0; s2_address = 13'h11;
    @(negedge clk);
    check("coll_rw_accept", 64'(s1_waitrequest), 64'(0));
    @(posedge clk);
    #1;
    s1_chipselect = 1'b0; s1_write = 1'b0; s2_chipselect = 1'b0;
    mdl[16'h11] = 64'h77;
    s2_read_t(13'h11, 64'h77);

    // s1 read of the word s2 writes in the same cycle returns old data.
    old = mdl[16'h12];
    s1_chipselect = 1'b1; s1_read = 1'b1; s1_address = 13'h12; s1_burstcount = 5'd1;
    s2_chipselect = 1'b1; s2_write = 1'b1; s2_address = 13'h12;
    s2_byteenable = 8'hFF; s2_writedata = 64'h99;
    @(negedge clk);
    check("coll_wr_accept", 64'(s1_waitrequest), 64'(0));
    @(posedge clk);
    #1;
    s1q.push_back('{cyc + 1, old});
    s1_chipselect = 1'b0; s1_read = 1'b0; s2_chipselect = 1'b0; s2_write = 1'b0;
    mdl[16'h12] = 64'h99;
    s2_read_t(13'h12, 64'h99);

    // Frozen write burst leaves RAM untouched and the FSM idle afterwards.
    freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin wdata[i] = 64'hDEAD_0000 + 64'(i); wbe[i] = 8'hFF; end
    s1_write_burst(13'h30, 3, -1);
    freeze = 1'b0;
    @(negedge clk);
    check("freeze_fsm_idle", 64'(s1_waitrequest), 64'(0));
    @(posedge clk);
    #1;
    s1_read_burst(13'h30, 3, 1'b1);

    // Clock-enable stall in the middle of a read burst.
    s1_chipselect = 1'b1; s1_read = 1'b1; s1_address = 13'h100; s1_burstcount = 5'd8;
    wait_accept(acc);
    s1_chipselect = 1'b0; s1_read = 1'b0;
    for (int i = 0; i < 8; i++) s1q.push_back('{-1, mdl[16'h100 + i]});
    repeat (2) begin @(posedge clk); #1; end
    clken = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("clken_low_valid", 64'(s1_readdatavalid), 64'(0));
      check("clken_low_wait", 64'(s1_waitrequest), 64'(1));
    end
    @(posedge clk);
    #1;
    clken = 1'b1;
    wait_idle("clken_burst_end_timeout");

    // Reset in cycle 2 of an 8-beat read burst abandons it.
    s1_chipselect = 1'b1; s1_read = 1'b1; s1_address = 13'h140; s1_burstcount = 5'd8;
    wait_accept(acc);
    s1_chipselect = 1'b0; s1_read = 1'b0;
    for (int i = 0; i < 8; i++) s1q.push_back('{acc + 1 + i, mdl[16'h140 + i]});
    repeat (2) begin @(posedge clk); #1; end
    reset_n = 1'b0;
    s1q.delete();
    repeat (2) begin
      @(negedge clk);
      check("reset_mid_valid", 64'(s1_readdatavalid), 64'(0));
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    s1_read_burst(13'h1FFE, 4, 1'b1);

    // Burstcount 0 and oversize bursts.
    s1_read_burst(13'h105, 0, 1'b1);
    s1_read_burst(13'h110, 31, 1'b1);
    for (int i = 0; i < 16; i++) begin wdata[i] = {$urandom, $urandom}; wbe[i] = 8'(i * 17 + 3); end
    s1_write_burst(13'h120, 0, -1);
    s1_write_burst(13'h140, 20, 5);
    s1_read_burst(13'h140, 16, 1'b1);

    // Randomised traffic over the preloaded window.
    for (int it = 0; it < 40; it++) begin
      k = int'($urandom_range(0, 3));
      case (k)
        0: begin
          for (int i = 0; i < 16; i++) begin wdata[i] = {$urandom, $urandom}; wbe[i] = 8'($urandom); end
          s1_write_burst(13'(16'h100 + $urandom_range(0, 16'h6F)), int'($urandom_range(0, 31)),
                         int'($urandom_range(0, 20)));
        end
        1: s1_read_burst(13'(16'h100 + $urandom_range(0, 16'h6F)), int'($urandom_range(0, 31)), 1'b1);
        2: s2_write_t(13'(16'h100 + $urandom_range(0, 16'h7F)), {$urandom, $urandom}, 8'($urandom));
        default: begin
          acc = int'(16'h100 + $urandom_range(0, 16'h7F));
          s2_read_t(13'(acc), mdl[acc]);
        end
      endcase
    end

    k = 0;
    while ((s1q.size() > 0 || s2q.size() > 0) && k < 100) begin
      @(posedge clk);
      k++;
    end
    #1;
    check("s1_scoreboard_drained", 64'(s1q.size()), 64'(0));
    check("s2_scoreboard_drained", 64'(s2q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
